cmul_arb: RTL

- Shares one pipelined complex multiplier between two butterfly lanes (A, B) in the FFT BF_ALU.
- Each lane presents a butterfly operand and a twiddle with a valid/ready handshake. A round-robin arbiter grants one lane per cycle.
- Products return on a single output stream, tagged with the lane id, with output backpressure.

---
 rtl/cmul_arb_if.sv | 46 ++++
 rtl/cmul_arb.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cmul_arb_if.sv
// Request/result bundle for the shared complex multiplier: two requesting
// butterfly lanes (A, B) and one tagged result stream.
interface cmul_arb_if #(
    parameter int unsigned BFLY = 10,
    parameter int unsigned TW   = 9
);
    localparam int unsigned OW = BFLY + TW + 1;

    logic            a_valid;
    logic            a_ready;
    logic [BFLY-1:0] a_bfly_re;
    logic [BFLY-1:0] a_bfly_im;
    logic [TW-1:0]   a_tw_re;
    logic [TW-1:0]   a_tw_im;

    logic            b_valid;
    logic            b_ready;
    logic [BFLY-1:0] b_bfly_re;
    logic [BFLY-1:0] b_bfly_im;
    logic [TW-1:0]   b_tw_re;
    logic [TW-1:0]   b_tw_im;

    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_re;
    logic [OW-1:0]   out_im;
    logic            out_id;

    // Requester/consumer side
    modport master (
        output a_valid, a_bfly_re, a_bfly_im, a_tw_re, a_tw_im,
        output b_valid, b_bfly_re, b_bfly_im, b_tw_re, b_tw_im,
        output out_ready,
        input  a_ready, b_ready,
        input  out_valid, out_re, out_im, out_id
    );

    // Multiplier side
    modport slave (
        input  a_valid, a_bfly_re, a_bfly_im, a_tw_re, a_tw_im,
        input  b_valid, b_bfly_re, b_bfly_im, b_tw_re, b_tw_im,
        input  out_ready,
        output a_ready, b_ready,
        output out_valid, out_re, out_im, out_id
    );
endinterface

// File: rtl/cmul_arb.sv
// Two-lane round-robin front end for one two-stage pipelined complex
// multiplier. Stage 1 holds the four partial products, stage 2 the
// sum/difference; results leave tagged with the requesting lane.
module cmul_arb #(
    parameter int unsigned BFLY = 10,
    parameter int unsigned TW   = 9
) (
    input logic       clk,
    input logic       rst_n,
    cmul_arb_if.slave bus
);
    localparam int unsigned PW = BFLY + TW;
    localparam int unsigned OW = BFLY + TW + 1;

    logic en;
    logic grant_a;
    logic grant_b;
    logic xfer;

    logic signed [PW-1:0] op_bre;
    logic signed [PW-1:0] op_bim;
    logic signed [PW-1:0] op_twre;
    logic signed [PW-1:0] op_twim;

    logic                 prio_q, prio_d;
    logic                 v1_q, v1_d;
    logic                 id1_q, id1_d;
    logic signed [PW-1:0] pp_rr_q, pp_rr_d;
    logic signed [PW-1:0] pp_ii_q, pp_ii_d;
    logic signed [PW-1:0] pp_ir_q, pp_ir_d;
    logic signed [PW-1:0] pp_ri_q, pp_ri_d;
    logic                 v2_q, v2_d;
    logic                 id2_q, id2_d;
    logic signed [OW-1:0] re_q, re_d;
    logic signed [OW-1:0] im_q, im_d;

    // Stall whenever a result sits at the output and is not being taken.
    assign en = !(v2_q && !bus.out_ready);

    // Grant depends only on valids and the pointer, never on ready.
    assign grant_a = bus.a_valid && (!bus.b_valid || !prio_q);
    assign grant_b = bus.b_valid && (!bus.a_valid || prio_q);

    // Ready is forced low while reset is applied.
    assign bus.a_ready = rst_n && en && grant_a;
    assign bus.b_ready = rst_n && en && grant_b;
    assign xfer        = bus.a_ready || bus.b_ready;

    // Operand select, sign-extended to product width.
    always_comb begin
        if (grant_b) begin
            op_bre  = PW'(signed'(bus.b_bfly_re));
            op_bim  = PW'(signed'(bus.b_bfly_im));
            op_twre = PW'(signed'(bus.b_tw_re));
            op_twim = PW'(signed'(bus.b_tw_im));
        end else begin
            op_bre  = PW'(signed'(bus.a_bfly_re));
            op_bim  = PW'(signed'(bus.a_bfly_im));
            op_twre = PW'(signed'(bus.a_tw_re));
            op_twim = PW'(signed'(bus.a_tw_im));
        end
    end

    // Next state for the pointer and both pipeline stages.
    always_comb begin
        prio_d  = prio_q;
        v1_d    = v1_q;
        id1_d   = id1_q;
        pp_rr_d = pp_rr_q;
        pp_ii_d = pp_ii_q;
        pp_ir_d = pp_ir_q;
        pp_ri_d = pp_ri_q;
        v2_d    = v2_q;
        id2_d   = id2_q;
        re_d    = re_q;
        im_d    = im_q;

        // Point at the lane that was not served.
        if (xfer) begin
            prio_d = grant_a;
        end

        if (en) begin
            v1_d    = xfer;
            id1_d   = grant_b;
            // Full-scale products fit PW bits exactly, so no truncation occurs.
            pp_rr_d = op_bre * op_twre;
            pp_ii_d = op_bim * op_twim;
            pp_ir_d = op_bim * op_twre;
            pp_ri_d = op_bre * op_twim;

            v2_d    = v1_q;
            id2_d   = id1_q;
            re_d    = OW'(pp_rr_q) - OW'(pp_ii_q);
            im_d    = OW'(pp_ir_q) + OW'(pp_ri_q);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q  <= 1'b0;
            v1_q    <= 1'b0;
            id1_q   <= 1'b0;
            pp_rr_q <= '0;
            pp_ii_q <= '0;
            pp_ir_q <= '0;
            pp_ri_q <= '0;
            v2_q    <= 1'b0;
            id2_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            prio_q  <= prio_d;
            v1_q    <= v1_d;
            id1_q   <= id1_d;
            pp_rr_q <= pp_rr_d;
            pp_ii_q <= pp_ii_d;
            pp_ir_q <= pp_ir_d;
            pp_ri_q <= pp_ri_d;
            v2_q    <= v2_d;
            id2_q   <= id2_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign bus.out_valid = v2_q;
    assign bus.out_re    = re_q;
    assign bus.out_im    = im_q;
    assign bus.out_id    = id2_q;
endmodule
